// File: rtl/ae_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ae_pkg
// Description : Shared constants and grid-size helpers for the AE gain-grid
//               path (statistics writer, grid fetch, bilinear interpolator).
//               The grid has one node per corner of each 32x32 pixel block,
//               so a dimension of n pixels needs ceil(n/32)+1 nodes.
// Revision    : 1.0 - initial release
// ============================================================================
package ae_pkg;

    localparam int BLK_SHIFT = 5;   // log2 of the block edge (32 pixels)
    localparam int FRAC_W    = 5;   // in-block position bits
    localparam int GAIN_W    = 8;   // node gain width

    // Number of grid nodes along a dimension of n pixels.
    function automatic int grid_dim(input int n);
        return (n + (1 << BLK_SHIFT) - 1) / (1 << BLK_SHIFT) + 1;
    endfunction

    // Address/counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : ae_pkg
`default_nettype wire

// File: rtl/ae_grid_ram.sv
`default_nettype none
// ============================================================================
// Module      : ae_grid_ram
// Description : Double-banked AE grid node store. One write port selects its
//               bank explicitly; NRD independent read ports share one bank
//               select and register their data when rd_en_i is high (they
//               hold otherwise). The array itself is not reset; only the read
//               registers are. Small enough to land in distributed RAM (one
//               copy per read port) or plain flops.
// Revision    : 1.0 - initial release
// Ports       : clk         system clock
//               rst_n       asynchronous active-low reset (read registers)
//               wr_en_i     write strobe (address already range-checked)
//               wr_bank_i   bank written
//               wr_addr_i   node index
//               wr_data_i   node value
//               rd_en_i     capture new read data
//               rd_bank_i   bank read by all ports
//               rd_addr_i   per-port node index
//               rd_data_o   per-port registered node value
// ============================================================================
module ae_grid_ram #(
    parameter int DEPTH  = 9,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int NRD    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en_i,
    input  logic                          wr_bank_i,
    input  logic [ADDR_W-1:0]             wr_addr_i,
    input  logic [DATA_W-1:0]             wr_data_i,
    input  logic                          rd_en_i,
    input  logic                          rd_bank_i,
    input  logic [NRD-1:0][ADDR_W-1:0]    rd_addr_i,
    output logic [NRD-1:0][DATA_W-1:0]    rd_data_o
);

    logic [DATA_W-1:0] mem_q [2][DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_bank_i][wr_addr_i] <= wr_data_i;
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [DATA_W-1:0] rd_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_q <= '0;
            end else if (rd_en_i) begin
                rd_q <= mem_q[rd_bank_i][rd_addr_i[g]];
            end
        end

        assign rd_data_o[g] = rd_q;
    end

endmodule : ae_grid_ram
`default_nettype wire

// File: rtl/ae_grid_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ae_grid_fetch
// Description : Producer side of the AE bilinear interpolator. Tracks the
//               raster position of the pixel stream and, two cycles after
//               each accepted pixel, presents the four surrounding grid node
//               gains plus the in-block fractional position. Gains live in a
//               double-buffered node store; the control path fills the shadow
//               bank, commits it, and the banks swap on the next frame start.
// Revision    : 1.0 - initial release
// Ports       : clk        system clock
//               rst_n      asynchronous active-low reset
//               i_sof      start-of-frame pulse (may carry pixel (0,0))
//               i_vld      pixel strobe, raster order
//               wr_en      shadow-bank node write strobe
//               wr_addr    node index = row*GRID_W + col
//               wr_data    node gain
//               wr_commit  shadow bank complete; swap at next i_sof
//               o_wr_busy  commit pending, writes ignored
//               d0..d3     nodes (by,bx) (by,bx+1) (by+1,bx) (by+1,bx+1)
//               frac_h     y[4:0] of the pixel
//               frac_w     x[4:0] of the pixel
//               o_vld      output qualifier
//               o_err      sticky: pixel strobe after frame end
// ============================================================================
module ae_grid_fetch
    import ae_pkg::*;
#(
    parameter  int IMG_W  = 1280,
    parameter  int IMG_H  = 720,
    localparam int GRID_W = grid_dim(IMG_W),
    localparam int GRID_H = grid_dim(IMG_H),
    localparam int NODES  = GRID_W * GRID_H,
    localparam int ADDR_W = clog2_min1(NODES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_sof,
    input  logic              i_vld,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [GAIN_W-1:0] wr_data,
    input  logic              wr_commit,
    output logic              o_wr_busy,
    output logic [GAIN_W-1:0] d0,
    output logic [GAIN_W-1:0] d1,
    output logic [GAIN_W-1:0] d2,
    output logic [GAIN_W-1:0] d3,
    output logic [FRAC_W-1:0] frac_h,
    output logic [FRAC_W-1:0] frac_w,
    output logic              o_vld,
    output logic              o_err
);

    localparam int XW = clog2_min1(IMG_W);
    localparam int YW = clog2_min1(IMG_H);

    // ------------------------------------------------------------------
    // Frame / bank control state
    // ------------------------------------------------------------------
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          pend_q, pend_d;
    logic          act_q, act_d;
    logic          gok_q, gok_d;

    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic          cur_done;
    logic          take;
    logic          swap;
    logic          bank_now;
    logic          gok_now;

    always_comb begin
        // i_sof rewinds the raster before the accompanying pixel is taken.
        cur_x    = i_sof ? '0   : x_q;
        cur_y    = i_sof ? '0   : y_q;
        cur_done = i_sof ? 1'b0 : done_q;
        take     = i_vld & ~cur_done;

        // A commit arriving together with i_sof still swaps on that i_sof,
        // and the pixel riding on it already reads the new bank.
        swap     = i_sof & (pend_q | wr_commit);
        bank_now = act_q ^ swap;
        gok_now  = gok_q | swap;

        x_d    = cur_x;
        y_d    = cur_y;
        done_d = cur_done;
        if (take) begin
            if (cur_x == XW'(IMG_W - 1)) begin
                x_d = '0;
                if (cur_y == YW'(IMG_H - 1)) begin
                    y_d    = '0;
                    done_d = 1'b1;
                end else begin
                    y_d = cur_y + YW'(1);
                end
            end else begin
                x_d = cur_x + XW'(1);
            end
        end

        err_d  = (err_q & ~i_sof) | (i_vld & cur_done);

        pend_d = swap ? 1'b0 : (pend_q | wr_commit);
        act_d  = bank_now;
        gok_d  = gok_now;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            pend_q <= 1'b0;
            act_q  <= 1'b0;
            gok_q  <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            done_q <= done_d;
            err_q  <= err_d;
            pend_q <= pend_d;
            act_q  <= act_d;
            gok_q  <= gok_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: block index, fraction, and the bank this pixel must read
    // ------------------------------------------------------------------
    logic              s1_vld_q;
    logic [ADDR_W-1:0] s1_bx_q;
    logic [ADDR_W-1:0] s1_by_q;
    logic [FRAC_W-1:0] s1_fw_q;
    logic [FRAC_W-1:0] s1_fh_q;
    logic              s1_bank_q;
    logic              s1_gok_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_bx_q   <= '0;
            s1_by_q   <= '0;
            s1_fw_q   <= '0;
            s1_fh_q   <= '0;
            s1_bank_q <= 1'b0;
            s1_gok_q  <= 1'b0;
        end else begin
            s1_vld_q <= take;
            if (take) begin
                s1_bx_q   <= ADDR_W'(cur_x >> BLK_SHIFT);
                s1_by_q   <= ADDR_W'(cur_y >> BLK_SHIFT);
                s1_fw_q   <= FRAC_W'(cur_x);
                s1_fh_q   <= FRAC_W'(cur_y);
                s1_bank_q <= bank_now;
                s1_gok_q  <= gok_now;
            end
        end
    end

    // The four corner addresses. bx+1 and by+1 never leave the grid because
    // the grid carries one extra node per dimension.
    int                       base_idx;
    logic [3:0][ADDR_W-1:0]   rd_addr;
    logic [3:0][GAIN_W-1:0]   rd_data;

    always_comb begin
        base_idx   = int'(s1_by_q) * GRID_W + int'(s1_bx_q);
        rd_addr[0] = ADDR_W'(base_idx);
        rd_addr[1] = ADDR_W'(base_idx + 1);
        rd_addr[2] = ADDR_W'(base_idx + GRID_W);
        rd_addr[3] = ADDR_W'(base_idx + GRID_W + 1);
    end

    // ------------------------------------------------------------------
    // Node store: writes go to the bank not currently being read
    // ------------------------------------------------------------------
    logic wr_ok;
    assign wr_ok = wr_en & ~pend_q & (int'(wr_addr) < NODES);

    ae_grid_ram #(
        .DEPTH  (NODES),
        .ADDR_W (ADDR_W),
        .DATA_W (GAIN_W),
        .NRD    (4)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_ok),
        .wr_bank_i (~act_q),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_en_i   (s1_vld_q),
        .rd_bank_i (s1_bank_q),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    // ------------------------------------------------------------------
    // Stage 2: side-band aligned with the registered reads
    // ------------------------------------------------------------------
    logic              s2_vld_q;
    logic [FRAC_W-1:0] s2_fw_q;
    logic [FRAC_W-1:0] s2_fh_q;
    logic              s2_gok_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_q <= 1'b0;
            s2_fw_q  <= '0;
            s2_fh_q  <= '0;
            s2_gok_q <= 1'b0;
        end else begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_fw_q  <= s1_fw_q;
                s2_fh_q  <= s1_fh_q;
                s2_gok_q <= s1_gok_q;
            end
        end
    end

    // Until the first swap the node store holds nothing meaningful, so the
    // gains are masked to zero while the valid stream keeps flowing.
    assign d0        = s2_gok_q ? rd_data[0] : '0;
    assign d1        = s2_gok_q ? rd_data[1] : '0;
    assign d2        = s2_gok_q ? rd_data[2] : '0;
    assign d3        = s2_gok_q ? rd_data[3] : '0;
    assign frac_w    = s2_fw_q;
    assign frac_h    = s2_fh_q;
    assign o_vld     = s2_vld_q;
    assign o_err     = err_q;
    assign o_wr_busy = pend_q;

    a_idx_in_grid : assert property (
        @(posedge clk) disable iff (!rst_n)
        s1_vld_q |-> ((int'(s1_bx_q) + 1 <= GRID_W - 1) &&
                      (int'(s1_by_q) + 1 <= GRID_H - 1))
    );

endmodule : ae_grid_fetch
`default_nettype wire

// File: tb/tb_ae_grid_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ae_grid_fetch
// Description : Self-checking bench for ae_grid_fetch at 64x64 (3x3 grid).
//               A frame-level model predicts every output each cycle; a
//               literal table pins selected pixels to hand-computed gains.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ae_grid_fetch;

    localparam int W  = 64;
    localparam int H  = 64;
    localparam int GW = 3;
    localparam int NN = 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_sof = 1'b0;
    logic       i_vld = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       wr_commit = 1'b0;
    logic       o_wr_busy;
    logic [7:0] d0, d1, d2, d3;
    logic [4:0] frac_h, frac_w;
    logic       o_vld, o_err;

    ae_grid_fetch #(.IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_sof     (i_sof),
        .i_vld     (i_vld),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_commit (wr_commit),
        .o_wr_busy (o_wr_busy),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .frac_h    (frac_h),
        .frac_w    (frac_w),
        .o_vld     (o_vld),
        .o_err     (o_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- model state ----------------
    int m_mem [2][NN];
    int m_act, m_pend, m_gok, m_x, m_y, m_done, m_err;

    typedef struct {
        bit vld;
        int bank;
        bit gok;
        int x;
        int y;
    } pix_t;
    pix_t p1;

    // expected outputs, valid from just after a rising edge
    bit e_vld, e_busy, e_err;
    int e_d [4];
    int e_fh, e_fw, e_x, e_y;
    bit running = 1'b0;
    int lit_phase = -1;

    // ---------------- literal expectations ----------------
    localparam int NLIT = 6;
    int lit_ph [NLIT];
    int lit_x  [NLIT];
    int lit_y  [NLIT];
    int lit_d  [NLIT][4];
    int lit_f  [NLIT][2];

    task automatic set_lit(input int k, input int ph, input int x, input int y,
                           input int a, input int b, input int c, input int d,
                           input int fh, input int fw);
        lit_ph[k] = ph; lit_x[k] = x; lit_y[k] = y;
        lit_d[k][0] = a; lit_d[k][1] = b; lit_d[k][2] = c; lit_d[k][3] = d;
        lit_f[k][0] = fh; lit_f[k][1] = fw;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        n_cmp++;
        if (act !== ex) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, ex, $time);
        end
    endtask

    function automatic int node(input int b, input int r, input int c);
        return m_mem[b][r * GW + c];
    endfunction

    task automatic model_reset();
        m_act = 0; m_pend = 0; m_gok = 0;
        m_x = 0; m_y = 0; m_done = 0; m_err = 0;
        p1.vld = 1'b0; p1.bank = 0; p1.gok = 1'b0; p1.x = 0; p1.y = 0;
        e_vld = 1'b0; e_busy = 1'b0; e_err = 1'b0;
        for (int i = 0; i < 4; i++) e_d[i] = 0;
        e_fh = 0; e_fw = 0; e_x = 0; e_y = 0;
    endtask

    // One clock: drive inputs, advance the model, publish the outputs the
    // DUT must show after this rising edge.
    task automatic cyc(input bit sof, input bit vld, input bit wen,
                       input int wa, input int wd, input bit cm);
        pix_t np;
        bit   nx_vld;
        int   nd [4];
        int   nfh, nfw, nx, ny;
        bit   swap;
        i_sof = sof; i_vld = vld; wr_en = wen;
        wr_addr = wa[3:0]; wr_data = wd[7:0]; wr_commit = cm;

        nx_vld = p1.vld;
        nd = e_d; nfh = e_fh; nfw = e_fw; nx = e_x; ny = e_y;
        if (p1.vld) begin
            int by, bx;
            by = p1.y / 32;
            bx = p1.x / 32;
            nd[0] = p1.gok ? node(p1.bank, by,     bx)     : 0;
            nd[1] = p1.gok ? node(p1.bank, by,     bx + 1) : 0;
            nd[2] = p1.gok ? node(p1.bank, by + 1, bx)     : 0;
            nd[3] = p1.gok ? node(p1.bank, by + 1, bx + 1) : 0;
            nfh = p1.y % 32; nfw = p1.x % 32; nx = p1.x; ny = p1.y;
        end

        swap = sof && (m_pend != 0 || cm);
        if (sof) begin m_x = 0; m_y = 0; m_done = 0; m_err = 0; end
        np.vld  = vld && (m_done == 0);
        np.bank = swap ? 1 - m_act : m_act;
        np.gok  = swap || (m_gok != 0);
        np.x    = m_x;
        np.y    = m_y;
        if (vld && m_done != 0) m_err = 1;
        if (np.vld) begin
            if (m_x == W - 1) begin
                m_x = 0;
                if (m_y == H - 1) begin m_y = 0; m_done = 1; end
                else m_y++;
            end else begin
                m_x++;
            end
        end
        if (wen && m_pend == 0 && wa < NN) m_mem[1 - m_act][wa] = wd;
        if (swap) begin m_act = 1 - m_act; m_pend = 0; m_gok = 1; end
        else if (cm) m_pend = 1;

        @(posedge clk);
        e_vld = nx_vld; e_d = nd; e_fh = nfh; e_fw = nfw; e_x = nx; e_y = ny;
        e_busy = (m_pend != 0); e_err = (m_err != 0);
        p1 = np;
        #1;
    endtask

    task automatic do_mid_reset();
        #3;
        i_sof = 1'b0; i_vld = 1'b0; wr_en = 1'b0; wr_commit = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_o_vld", o_vld, 0);
        chk("midrst_busy", o_wr_busy, 0);
        chk("midrst_d0", d0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One frame of W*H pixels with optional gaps, shadow loads, a commit,
    // a write during busy, and a mid-frame reset.
    task automatic run_frame(input int gap, input int cm_pix, input int bw_pix,
                             input int ld_pix, input int rst_pix);
        for (int i = 0; i < W * H; i++) begin
            bit wen;
            int wa, wd;
            bit cm;
            wen = 1'b0; wa = 0; wd = 0; cm = 1'b0;
            if (gap > 0 && (i % gap) == gap - 1) cyc(0, 0, 0, 0, 0, 0);
            if (i == rst_pix) begin
                do_mid_reset();
                return;
            end
            if (ld_pix >= 0 && i >= ld_pix && i < ld_pix + NN) begin
                wen = 1'b1; wa = i - ld_pix; wd = 200 + wa;
            end
            if (i == cm_pix) cm = 1'b1;
            if (i == bw_pix) begin wen = 1'b1; wa = 0; wd = 99; end
            cyc(i == 0, 1, wen, wa, wd, cm);
            if (i == bw_pix) chk("busy_on_write", o_wr_busy, 1);
        end
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (running) begin
            chk("o_vld", o_vld, e_vld);
            chk("o_wr_busy", o_wr_busy, e_busy);
            chk("o_err", o_err, e_err);
            chk("d0", d0, e_d[0]);
            chk("d1", d1, e_d[1]);
            chk("d2", d2, e_d[2]);
            chk("d3", d3, e_d[3]);
            chk("frac_h", frac_h, e_fh);
            chk("frac_w", frac_w, e_fw);
            for (int k = 0; k < NLIT; k++) begin
                if (e_vld && lit_ph[k] == lit_phase && lit_x[k] == e_x && lit_y[k] == e_y) begin
                    chk("lit_vld", o_vld, 1);
                    chk("lit_d0", d0, lit_d[k][0]);
                    chk("lit_d1", d1, lit_d[k][1]);
                    chk("lit_d2", d2, lit_d[k][2]);
                    chk("lit_d3", d3, lit_d[k][3]);
                    chk("lit_frac_h", frac_h, lit_f[k][0]);
                    chk("lit_frac_w", frac_w, lit_f[k][1]);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        set_lit(0, 0, 63, 63,   0,   0,   0,   0, 31, 31);
        set_lit(1, 1,  0,  0,   0,  10,  30,  40,  0,  0);
        set_lit(2, 1, 37,  5,  10,  20,  40,  50,  5,  5);
        set_lit(3, 1, 63, 63,  40,  50,  70,  80, 31, 31);
        set_lit(4, 2,  0,  0, 200, 201, 203, 204,  0,  0);
        set_lit(5, 3,  0,  0,   0,   0,   0,   0,  0,  0);
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < NN; k++) m_mem[b][k] = 0;
        model_reset();
        running = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_o_vld", o_vld, 0);
        chk("reset_busy", o_wr_busy, 0);
        chk("reset_err", o_err, 0);
        chk("reset_d0", d0, 0);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);

        // Frame with no committed grid: gains all zero, valid still flows.
        lit_phase = 0;
        run_frame(7, -1, -1, -1, -1);

        // Strobe after the last pixel of the frame.
        cyc(0, 1, 0, 0, 0, 0);
        chk("err_after_extra", o_err, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("extra_no_vld", o_vld, 0);

        // Load node k = 10*k into the shadow bank, plus an out-of-range write.
        for (int k = 0; k < NN; k++) cyc(0, 0, 1, k, 10 * k, 0);
        cyc(0, 0, 1, 12, 77, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("busy_after_commit", o_wr_busy, 1);
        cyc(0, 0, 0, 0, 0, 0);

        // First frame on the committed grid; mid-frame shadow load + commit.
        lit_phase = 1;
        run_frame(0, 3000, 3001, 100, -1);
        chk("err_cleared_by_sof", o_err, 0);

        // New bank from pixel (0,0); commit, then reset in line 3.
        lit_phase = 2;
        run_frame(0, 100, -1, -1, 64 * 3 + 10);

        // After reset: no swap yet, restart at (0,0) with zero gains.
        lit_phase = 3;
        run_frame(5, -1, -1, -1, -1);

        running = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_ae_grid_fetch
`default_nettype wire

// File: doc/ae_grid_fetch.md
Name: ae_grid_fetch

Overview:
- Producer side of the AE bilinear interpolation unit. It tracks the raster position of an incoming pixel stream and, for each pixel, looks up the four surrounding AE grid nodes.
- Per pixel it emits d0..d3 plus 5-bit frac_h/frac_w, ready to drive the interpolator's inputs directly.
- Grid gains (8-bit, one per 32x32 block corner) are loaded by the AE statistics/control path into a double-buffered node memory. The new bank swaps in on frame start.

Parameters:
- IMG_W, 1280, active pixels per line.
- IMG_H, 720, active lines per frame.
- GRID_W, (IMG_W+31)/32+1, node columns (localparam, derived).
- GRID_H, (IMG_H+31)/32+1, node rows (localparam, derived).
- ADDR_W, clog2(GRID_W*GRID_H), node address width (localparam).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_sof  in  1  start of frame, one-cycle pulse; may coincide with the first i_vld
- i_vld  in  1  pixel strobe, raster order, no back-pressure
- wr_en  in  1  node write strobe (shadow bank)
- wr_addr  in  ADDR_W  node index = row*GRID_W+col
- wr_data  in  8  node gain
- wr_commit  in  1  pulse: shadow bank complete, swap at next i_sof
- o_wr_busy  out  1  high from commit until swap; wr_en ignored while high
- d0,d1,d2,d3  out  8 each  nodes (by,bx),(by,bx+1),(by+1,bx),(by+1,bx+1)
- frac_h  out  5  y[4:0]
- frac_w  out  5  x[4:0]
- o_vld  out  1  output qualifier
- o_err  out  1  sticky: i_vld after the last pixel of a frame; cleared by i_sof

Behaviour:
- Reset: all outputs 0, x=y=0, active bank=0, pending=0, grid_ok=0, frame_done=0. Node memory is not reset.
- Position counters:
  - i_sof forces x=y=0 and frame_done=0. An i_vld in the same cycle is pixel (0,0); the next pixel is (1,0).
  - Each i_vld takes the current (x,y), then advances: x+1, or x=0/y+1 when x==IMG_W-1.
  - At (IMG_W-1, IMG_H-1) the pixel is processed, then frame_done=1.
  - i_vld while frame_done: no o_vld for that strobe, o_err=1, counters hold.
- Pipeline, latency 2:
  - Cycle N+1: register bx=x>>5, by=y>>5, frac_w, frac_h, vld.
  - Cycle N+2: register the four memory reads from the active bank, with o_vld=1.
  - frac_h and frac_w are delayed alongside the reads so they arrive aligned with d0..d3.
- Gaps in i_vld give o_vld=0. Data outputs hold their last values.
- Writes:
  - wr_en && !o_wr_busy writes the shadow bank (=~active).
  - A write with wr_addr >= GRID_W*GRID_H is dropped.
- Bank swap:
  - wr_commit sets pending=1 (o_wr_busy=1).
  - On i_sof with pending=1 (including the same cycle as wr_commit): active flips, pending=0, grid_ok=1. The swap takes effect for the pixel accompanying that i_sof.
  - wr_commit while pending=1 has no further effect.
- grid_ok=0 (no swap yet since reset): d0..d3 are forced to 0 but o_vld still flows.
- Reset asserted mid-frame: the pipeline flushes immediately (o_vld=0 asynchronously), and pending and the bank select return to reset values.
- Index arithmetic: bx+1 <= GRID_W-1 and by+1 <= GRID_H-1 always hold because of the derived grid size, so no clamp is needed. An assertion checks this.

Decomposition:
- Shared package ae_pkg: BLK_SHIFT=5, FRAC_W=5, GAIN_W=8, and the grid-size functions used by this block, the statistics writer, and the interpolator.
- One sub-module, ae_grid_ram:
  - two banks, each GRID_W*GRID_H x 8;
  - one write port and four registered read ports with a bank select;
  - maps to distributed RAM (4 read copies) or a register array.

Test Plan (IMG_W=64, IMG_H=64 => 3x3 grid):
- Load node k=10*k, commit, i_sof+i_vld at (0,0) -> 2 cycles later o_vld=1, d0..d3=0,10,30,40, frac_h=frac_w=0.
- Stream to pixel (37,5) -> d0..d3=10,20,40,50, frac_w=5, frac_h=5; pixel (63,63) -> d0..d3=40,50,70,80, frac=31/31.
- No commit since reset, stream a frame -> o_vld on every pixel, d0..d3 all 0.
- Commit mid-frame, write during busy (addr0=99) -> write ignored, o_wr_busy=1; old bank used until the next i_sof, new values from pixel (0,0) of the next frame.
- After pixel 4095, one extra i_vld -> no o_vld for it, o_err=1; next i_sof -> o_err=0.
- rst_n low in the middle of line 3 -> o_vld=0 at once, o_wr_busy=0; after release, first i_sof restarts at (0,0).
